// File: rtl/cpu_trace_dumper.sv
// cpu_trace_dumper: stalls the CPU after each retired step and streams one trace
// record (PC beat, then one beat per architectural register) over a
// valid/ready channel, optionally terminated by an END beat after a
// fixed number of records.
module cpu_trace_dumper #(
    parameter int DATA_W      = 32,
    parameter int NREG        = 32,
    parameter int IDX_W       = 5,
    parameter int MAX_RECORDS = 30,
    parameter int SKIP_X0     = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [IDX_W-1:0]  reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic              trace_valid_o,
    input  logic              trace_ready_i,
    output logic [1:0]        trace_tag_o,
    output logic [IDX_W-1:0]  trace_idx_o,
    output logic [DATA_W-1:0] trace_data_o,
    output logic              cpu_stall_o,
    output logic              done_o,
    output logic [15:0]       rec_cnt_o
);

    localparam logic [1:0]       TAG_PC    = 2'd0;
    localparam logic [1:0]       TAG_REG   = 2'd1;
    localparam logic [1:0]       TAG_END   = 2'd2;
    localparam logic [IDX_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? IDX_W'(1) : IDX_W'(0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREG - 1);
    localparam logic [15:0]      MAX_REC   = 16'(MAX_RECORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND_PC,
        ST_READ,
        ST_SEND_REG,
        ST_SEND_END,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic [15:0]         rec_q, rec_d;
    // Second cycle of READ: register file data is valid on reg_data_i.
    logic                rd_ph_q, rd_ph_d;
    logic [15:0]         rec_inc;

    // Record counter saturates instead of wrapping.
    assign rec_inc    = (rec_q == 16'hFFFF) ? rec_q : rec_q + 16'd1;
    assign reg_addr_o = idx_q;
    assign rec_cnt_o  = rec_q;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pc_q    <= '0;
            cap_q   <= '0;
            rec_q   <= '0;
            rd_ph_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            cap_q   <= cap_d;
            rec_q   <= rec_d;
            rd_ph_q <= rd_ph_d;
        end
    end

    // Next-state logic and beat outputs; outputs depend only on registered
    // state so a stalled beat stays stable until it is accepted.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pc_d          = pc_q;
        cap_d         = cap_q;
        rec_d         = rec_q;
        rd_ph_d       = rd_ph_q;
        trace_valid_o = 1'b0;
        trace_tag_o   = TAG_PC;
        trace_idx_o   = '0;
        trace_data_o  = '0;
        cpu_stall_o   = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (step_i) begin
                    pc_d    = pc_i;
                    state_d = ST_SEND_PC;
                end
            end
            ST_SEND_PC: begin
                trace_valid_o = 1'b1;
                trace_data_o  = pc_q;
                cpu_stall_o   = 1'b1;
                if (trace_ready_i) begin
                    idx_d   = FIRST_IDX;
                    rd_ph_d = 1'b0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                cpu_stall_o = 1'b1;
                if (!rd_ph_q) begin
                    rd_ph_d = 1'b1;
                end else begin
                    cap_d   = reg_data_i;
                    rd_ph_d = 1'b0;
                    state_d = ST_SEND_REG;
                end
            end
            ST_SEND_REG: begin
                trace_valid_o = 1'b1;
                trace_tag_o   = TAG_REG;
                trace_idx_o   = idx_q;
                trace_data_o  = cap_q;
                cpu_stall_o   = 1'b1;
                if (trace_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        rec_d = rec_inc;
                        if ((MAX_RECORDS != 0) && (rec_inc == MAX_REC)) begin
                            state_d = ST_SEND_END;
                        end else if (start_i) begin
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_SEND_END: begin
                trace_valid_o = 1'b1;
                trace_tag_o   = TAG_END;
                trace_data_o  = DATA_W'(rec_q);
                cpu_stall_o   = 1'b1;
                if (trace_ready_i) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_trace_dumper.sv
// Bench for cpu_trace_dumper: three instances (default, record limit 2,
// skip-x0 with 8 registers) share one register file. A reference model
// pushes whole expected records into per-instance queues when a step is
// issued; a monitor pops and compares each accepted beat.
module tb_cpu_trace_dumper;

    typedef struct packed {
        logic [1:0]  tag;
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        start  [3];
    logic        step   [3];
    logic        ready  [3];
    logic [31:0] pc     [3];
    logic [4:0]  raddr  [3];
    logic [31:0] rdata  [3];
    logic        valid  [3];
    logic [1:0]  tag    [3];
    logic [4:0]  tidx   [3];
    logic [31:0] tdata  [3];
    logic        stall  [3];
    logic        done   [3];
    logic [15:0] rec    [3];
    logic [2:0]  raddr_c;
    logic [2:0]  tidx_c;

    logic [31:0] regfile [32];
    beat_t       exp_q   [3][$];
    int          mrec    [3];
    bit          mdone   [3];
    bit          armed   [3];
    bit          rand_rdy[3];
    bit          force_low[3];
    bit          hold_pend[3];
    beat_t       hold_b  [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam int NREG_M [3] = '{32, 32, 8};
    localparam int FIRST_M[3] = '{0, 0, 1};
    localparam int LIMIT_M[3] = '{30, 2, 0};

    assign raddr[2] = {2'b00, raddr_c};
    assign tidx[2]  = {2'b00, tidx_c};

    cpu_trace_dumper u_dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[0]), .step_i(step[0]), .pc_i(pc[0]),
        .reg_addr_o(raddr[0]), .reg_data_i(rdata[0]), .trace_valid_o(valid[0]),
        .trace_ready_i(ready[0]), .trace_tag_o(tag[0]), .trace_idx_o(tidx[0]),
        .trace_data_o(tdata[0]), .cpu_stall_o(stall[0]), .done_o(done[0]), .rec_cnt_o(rec[0])
    );

    cpu_trace_dumper #(.MAX_RECORDS(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[1]), .step_i(step[1]), .pc_i(pc[1]),
        .reg_addr_o(raddr[1]), .reg_data_i(rdata[1]), .trace_valid_o(valid[1]),
        .trace_ready_i(ready[1]), .trace_tag_o(tag[1]), .trace_idx_o(tidx[1]),
        .trace_data_o(tdata[1]), .cpu_stall_o(stall[1]), .done_o(done[1]), .rec_cnt_o(rec[1])
    );

    cpu_trace_dumper #(.NREG(8), .IDX_W(3), .MAX_RECORDS(0), .SKIP_X0(1)) u_dut_c (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[2]), .step_i(step[2]), .pc_i(pc[2]),
        .reg_addr_o(raddr_c), .reg_data_i(rdata[2]), .trace_valid_o(valid[2]),
        .trace_ready_i(ready[2]), .trace_tag_o(tag[2]), .trace_idx_o(tidx_c),
        .trace_data_o(tdata[2]), .cpu_stall_o(stall[2]), .done_o(done[2]), .rec_cnt_o(rec[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read register file: data follows the address by one clock.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) rdata[k] <= regfile[raddr[k]];
    end

    // Sink ready: forced low, randomly throttled, or always ready.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (force_low[k])     ready[k] = 1'b0;
            else if (rand_rdy[k]) ready[k] = ($urandom_range(3) != 0);
            else                  ready[k] = 1'b1;
        end
    end

    // Monitor: every accepted beat is matched against the scoreboard; a
    // stalled beat must reappear unchanged on the next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) hold_pend[k] = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                beat_t got;
                beat_t e;
                got = {tag[k], tidx[k], tdata[k]};
                if (hold_pend[k]) begin
                    n_checks++;
                    if (!valid[k] || got !== hold_b[k]) begin
                        n_fail++;
                        $display("FAIL hold_dut%0d: valid=%0b beat=%h required held beat %h",
                                 k, valid[k], got, hold_b[k]);
                    end
                end
                if (valid[k]) begin
                    n_checks++;
                    if (stall[k] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_dut%0d: stall=%0b during beat, required 1", k, stall[k]);
                    end
                    if (ready[k]) begin
                        n_checks++;
                        if (exp_q[k].size() == 0) begin
                            n_fail++;
                            $display("FAIL beat_dut%0d: unexpected beat tag=%0d idx=%0d data=0x%0h, none required",
                                     k, tag[k], tidx[k], tdata[k]);
                        end else begin
                            e = exp_q[k].pop_front();
                            if (got !== e) begin
                                n_fail++;
                                $display("FAIL beat_dut%0d: got tag=%0d idx=%0d data=0x%0h required tag=%0d idx=%0d data=0x%0h",
                                         k, tag[k], tidx[k], tdata[k], e.tag, e.idx, e.data);
                            end else begin
                                $display("dut%0d beat tag=%0d idx=%0d data=0x%0h ok", k, tag[k], tidx[k], tdata[k]);
                            end
                        end
                    end
                end
                hold_pend[k] = valid[k] && !ready[k];
                hold_b[k]    = got;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end else begin
            $display("check %s = 0x%0h ok", nm, act);
        end
    endtask

    // Reference model: one accepted step yields a PC beat, one beat per
    // scanned register, and an END beat once the record limit is reached.
    task automatic push_record(int k, logic [31:0] p);
        exp_q[k].push_back({2'd0, 5'd0, p});
        for (int i = FIRST_M[k]; i < NREG_M[k]; i++)
            exp_q[k].push_back({2'd1, 5'(i), regfile[i]});
        if (mrec[k] < 65535) mrec[k]++;
        if (LIMIT_M[k] != 0 && mrec[k] == LIMIT_M[k]) begin
            exp_q[k].push_back({2'd2, 5'd0, 32'(mrec[k])});
            mdone[k] = 1'b1;
            armed[k] = 1'b0;
        end
    endtask

    task automatic set_start(int k);
        @(posedge clk); #1;
        start[k] = 1'b1;
        armed[k] = !mdone[k];
    endtask

    task automatic do_step(int k, logic [31:0] p);
        @(posedge clk); #1;
        pc[k]   = p;
        step[k] = 1'b1;
        if (armed[k] && !mdone[k]) push_record(k, p);
        @(posedge clk); #1;
        step[k] = 1'b0;
    endtask

    task automatic wait_drain(int k);
        int n;
        n = 0;
        while (exp_q[k].size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q[k].size() != 0) begin
            n_fail++;
            $display("FAIL drain_dut%0d: %0d beats outstanding after timeout, required 0", k, exp_q[k].size());
            exp_q[k].delete();
        end
        repeat (3) @(posedge clk);
    endtask

    // Returns at a falling edge where the instance presents the given beat.
    task automatic wait_beat(int k, logic [1:0] t, logic [4:0] ix);
        int n;
        n = 0;
        @(negedge clk);
        while (!(valid[k] && tag[k] == t && tidx[k] == ix) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 3000) begin
            n_fail++;
            $display("FAIL wait_dut%0d: beat tag=%0d idx=%0d never seen, required it", k, t, ix);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            mrec[k]  = 0;
            mdone[k] = 1'b0;
            armed[k] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regfile[i] = 32'(i * 3);
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; step[k] = 1'b0; pc[k] = '0;
            rand_rdy[k] = 1'b0; force_low[k] = 1'b0; hold_pend[k] = 1'b0;
            ready[k] = 1'b1;
        end
        clear_model();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset state of every instance.
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), 32'(valid[k]), 0);
            chk($sformatf("rst_stall%0d", k), 32'(stall[k]), 0);
            chk($sformatf("rst_done%0d", k),  32'(done[k]),  0);
            chk($sformatf("rst_rec%0d", k),   32'(rec[k]),   0);
            chk($sformatf("rst_raddr%0d", k), 32'(raddr[k]), 0);
            chk($sformatf("rst_tdata%0d", k), tdata[k],      0);
        end

        // Skip-x0 instance, 8 registers, throttled sink: idx 1..7 only.
        rand_rdy[2] = 1'b1;
        set_start(2);
        do_step(2, $urandom);
        wait_drain(2);
        chk("rec_skip", 32'(rec[2]), 1);

        // Record limit 2: END beat carries 2, done rises, further steps ignored.
        set_start(1);
        do_step(1, 32'h100);
        wait_drain(1);
        do_step(1, 32'h200);
        wait_drain(1);
        chk("done_limit", 32'(done[1]), 1);
        chk("rec_limit", 32'(rec[1]), 2);
        do_step(1, 32'h300);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stall_after_done", 32'(stall[1]), 0);
        chk("done_hold", 32'(done[1]), 1);
        chk("rec_after_done", 32'(rec[1]), 2);

        // Basic record on the default instance: PC 0x10, regfile i*3.
        set_start(0);
        do_step(0, 32'h10);
        wait_drain(0);
        chk("rec_basic", 32'(rec[0]), 1);

        // Backpressure on REG idx 7 for five cycles.
        do_step(0, 32'hABCD0000);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!(raddr[0] == 5'd7 && !valid[0] && stall[0]) && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        force_low[0] = 1'b1;
        wait_beat(0, 2'd1, 5'd7);
        repeat (5) @(negedge clk);
        chk("bp_valid", 32'(valid[0]), 1);
        chk("bp_idx", 32'(tidx[0]), 7);
        chk("bp_data", tdata[0], regfile[7]);
        force_low[0] = 1'b0;
        wait_drain(0);
        chk("rec_bp", 32'(rec[0]), 2);

        // Random records with random register contents and throttled sink.
        rand_rdy[0] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) regfile[i] = $urandom;
            do_step(0, $urandom);
            wait_drain(0);
            chk($sformatf("rec_rand%0d", r), 32'(rec[0]), 32'(mrec[0]));
        end
        rand_rdy[0] = 1'b0;

        // start_i drop at REG idx 20: record completes, then step ignored.
        do_step(0, 32'h2020);
        wait_beat(0, 2'd1, 5'd20);
        start[0] = 1'b0;
        armed[0] = 1'b0;
        wait_drain(0);
        chk("rec_drop", 32'(rec[0]), 6);
        do_step(0, 32'h3030);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stall_drop_idle", 32'(stall[0]), 0);
        chk("valid_drop_idle", 32'(valid[0]), 0);
        chk("rec_drop_idle", 32'(rec[0]), 6);

        // Reset during REG idx 12: outputs drop at once, fresh record afterwards.
        set_start(0);
        do_step(0, 32'h4040);
        wait_beat(0, 2'd1, 5'd12);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(valid[0]), 0);
        chk("mrst_stall", 32'(stall[0]), 0);
        chk("mrst_tag", 32'(tag[0]), 0);
        chk("mrst_data", tdata[0], 0);
        clear_model();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        armed[0] = 1'b1;
        @(negedge clk);
        chk("mrst_rec", 32'(rec[0]), 0);
        do_step(0, 32'h55);
        wait_drain(0);
        chk("rec_after_rst", 32'(rec[0]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
